// File: rtl/dmem_adapter.sv
// Data-memory adapter: turns one memory-stage load/store into a word-aligned
// bus transaction and returns the right-aligned, extended load result.
module dmem_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  input  logic [31:0] req_wdata,
  output logic        cmiss_stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_BU = 3'd4;
  localparam logic [2:0] TYP_HU = 3'd5;

  state_t            state_reg, state_next;
  logic [2:0]        typ_reg;
  logic [1:0]        off_reg;
  logic              we_reg;
  logic              mis_reg;
  logic              err_reg;
  logic [31:0]       resp_data_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              bus_req_valid_reg;
  logic [31:0]       bus_addr_reg;
  logic              bus_we_reg;
  logic [3:0]        bus_be_reg;
  logic [31:0]       bus_wdata_reg;

  logic              req_mis;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  logic              timeout_hit;

  // Size decode of the incoming request; X and unknown codes behave as W.
  always_comb begin
    req_mis    = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    if (req_typ == TYP_B || req_typ == TYP_BU) begin
      be_calc    = 4'b0001 << req_addr[1:0];
      wdata_calc = {4{req_wdata[7:0]}};
    end else if (req_typ == TYP_H || req_typ == TYP_HU) begin
      req_mis    = req_addr[0];
      be_calc    = 4'b0011 << req_addr[1:0];
      wdata_calc = {2{req_wdata[15:0]}};
    end else begin
      req_mis    = |req_addr[1:0];
    end
  end

  always_comb begin
    shifted = bus_rdata >> {off_reg, 3'b000};
    case (typ_reg)
      TYP_B:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      TYP_BU:  load_ext = {24'b0, shifted[7:0]};
      TYP_H:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      TYP_HU:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = req_mis ? DONE : REQ;
      REQ:  if (bus_req_ready) state_next = WAIT;
      WAIT: if (bus_resp_valid || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      typ_reg           <= 3'd0;
      off_reg           <= 2'd0;
      we_reg            <= 1'b0;
      mis_reg           <= 1'b0;
      err_reg           <= 1'b0;
      resp_data_reg     <= 32'd0;
      cnt_reg           <= '0;
      bus_req_valid_reg <= 1'b0;
      bus_addr_reg      <= 32'd0;
      bus_we_reg        <= 1'b0;
      bus_be_reg        <= 4'd0;
      bus_wdata_reg     <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req_valid) begin
          typ_reg       <= req_typ;
          off_reg       <= req_addr[1:0];
          we_reg        <= req_fcn;
          mis_reg       <= req_mis;
          err_reg       <= 1'b0;
          resp_data_reg <= 32'd0;
          if (!req_mis) begin
            bus_req_valid_reg <= 1'b1;
            bus_addr_reg      <= {req_addr[31:2], 2'b00};
            bus_we_reg        <= req_fcn;
            bus_be_reg        <= be_calc;
            bus_wdata_reg     <= wdata_calc;
          end
        end
        // Bus fields drop back to zero as soon as the request is accepted.
        REQ: if (bus_req_ready) begin
          bus_req_valid_reg <= 1'b0;
          bus_addr_reg      <= 32'd0;
          bus_we_reg        <= 1'b0;
          bus_be_reg        <= 4'd0;
          bus_wdata_reg     <= 32'd0;
          cnt_reg           <= '0;
        end
        WAIT: begin
          if (bus_resp_valid) begin
            resp_data_reg <= we_reg ? 32'd0 : load_ext;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (timeout_hit) err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmiss_stall   = rst_n & (((state_reg == IDLE) & req_valid) |
                                  (state_reg == REQ) | (state_reg == WAIT));
  assign resp_valid    = (state_reg == DONE);
  assign misaligned    = (state_reg == DONE) & mis_reg;
  assign bus_err       = (state_reg == DONE) & err_reg;
  assign resp_data     = (state_reg == DONE) ? resp_data_reg : 32'd0;
  assign bus_req_valid = bus_req_valid_reg;
  assign bus_addr      = bus_addr_reg;
  assign bus_we        = bus_we_reg;
  assign bus_be        = bus_be_reg;
  assign bus_wdata     = bus_wdata_reg;

endmodule

// File: tb/tb_dmem_adapter.sv
// Directed bench for dmem_adapter: a per-cycle compare process against a
// size/offset model, plus per-request literal data, latency and issue counts.
module tb_dmem_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_fcn = 1'b0;
  logic [2:0]  req_typ = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        cmiss_stall, resp_valid, misaligned, bus_err;
  logic [31:0] resp_data;
  logic        bus_req_valid, bus_we;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  int acc_total = 0;

  // Current request as seen by the bus model and compare process
  logic [2:0]  cur_typ = 3'd0;
  logic [31:0] cur_addr = 32'd0;
  logic        cur_fcn = 1'b0;
  logic [31:0] cur_wdata = 32'd0;
  logic [31:0] cur_rdata = 32'd0;
  int          cur_rdy_dly = 0;
  int          cur_resp_dly = 0;
  bit          cur_mute = 1'b0;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic        fcn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          resp_dly;
    bit          mute;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_issue;
  } vec_t;

  vec_t vecs[14];

  dmem_adapter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_fcn(req_fcn),
    .req_typ(req_typ), .req_wdata(req_wdata),
    .cmiss_stall(cmiss_stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: access size and offset arithmetic ----
  function automatic int sz(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd4) return 1;
    if (t == 3'd2 || t == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % sz(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    int b;
    b = ((1 << sz(t)) - 1) << int'(a[1:0]);
    return 4'(b);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] w);
    if (sz(t) == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (sz(t) == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] w);
    int n;
    longint v;
    longint span;
    n = sz(t);
    v = longint'(w >> (8 * int'(a[1:0])));
    if (n == 4) return 32'(v);
    span = longint'(1) << (8 * n);
    v = v % span;
    if ((t == 3'd1 || t == 3'd2) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_resp(input logic [2:0] t, input logic [31:0] a,
                                         input logic f, input bit mute, input logic [31:0] w);
    if (f || mute || m_mis(t, a)) return 32'd0;
    return m_load(t, a, w);
  endfunction

  function automatic logic [31:0] all_or();
    return resp_data | bus_addr | bus_wdata |
           {25'd0, cmiss_stall, resp_valid, misaligned, bus_err, bus_req_valid, bus_we, |bus_be};
  endfunction

  function automatic vec_t mk(input logic [2:0] typ, input logic [31:0] addr, input logic fcn,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int rdy, input int rsp, input bit mute,
                              input logic [31:0] exp_data, input int lat, input int iss);
    vec_t v;
    v.typ = typ; v.addr = addr; v.fcn = fcn; v.wdata = wdata; v.rdata = rdata;
    v.rdy_dly = rdy; v.resp_dly = rsp; v.mute = mute;
    v.exp_data = exp_data; v.exp_lat = lat; v.exp_issue = iss;
    return v;
  endfunction

  // ---- bus responder: decides ready/response on the falling edge ----
  initial begin
    int rcnt;
    int wcnt;
    bit waiting;
    rcnt = 0; wcnt = 0; waiting = 1'b0;
    forever begin
      @(negedge clk);
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      if (!rst_n) begin
        waiting = 1'b0;
        rcnt = 0;
      end else if (bus_req_valid) begin
        if (rcnt >= cur_rdy_dly) begin
          bus_req_ready = 1'b1;
          waiting = 1'b1;
          wcnt = 0;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else if (waiting) begin
        if (wcnt >= cur_resp_dly) begin
          waiting = 1'b0;
          if (!cur_mute) begin
            bus_resp_valid = 1'b1;
            bus_rdata = cur_rdata;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Count bus handshakes (pre-edge values)
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && bus_req_valid && bus_req_ready) acc_total++;
    end
  end

  // ---- per-cycle compare against the model ----
  initial begin
    bit prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", all_or(), 32'd0);
        prev_resp = 1'b0;
      end else begin
        chk("stall", cmiss_stall, req_valid && !resp_valid);
        if (bus_req_valid) begin
          chk("bus_on_misaligned", m_mis(cur_typ, cur_addr), 0);
          chk("bus_addr", bus_addr, {cur_addr[31:2], 2'b00});
          chk("bus_we", bus_we, cur_fcn);
          chk("bus_be", bus_be, m_be(cur_typ, cur_addr));
          if (cur_fcn) chk("bus_wdata", bus_wdata, m_wdata(cur_typ, cur_wdata));
        end else begin
          chk("bus_idle_zero", bus_addr | bus_wdata | {27'd0, bus_we, bus_be}, 32'd0);
        end
        if (resp_valid) begin
          chk("resp_single_pulse", prev_resp, 0);
          chk("resp_data_model", resp_data, m_resp(cur_typ, cur_addr, cur_fcn, cur_mute, cur_rdata));
          chk("misaligned_flag", misaligned, m_mis(cur_typ, cur_addr));
          chk("bus_err_flag", bus_err, cur_mute && !m_mis(cur_typ, cur_addr));
        end else begin
          chk("flags_idle", {misaligned, bus_err}, 0);
        end
        prev_resp = resp_valid;
      end
    end
  end

  task automatic start_req(input vec_t v);
    cur_typ = v.typ; cur_addr = v.addr; cur_fcn = v.fcn; cur_wdata = v.wdata;
    cur_rdata = v.rdata; cur_rdy_dly = v.rdy_dly; cur_resp_dly = v.resp_dly; cur_mute = v.mute;
    req_typ = v.typ; req_addr = v.addr; req_fcn = v.fcn; req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion cycle
  task automatic run_vec(input int idx);
    vec_t v;
    int a0;
    int lat;
    bit got;
    logic [31:0] rd;
    v = vecs[idx];
    chk("model_pin", m_resp(v.typ, v.addr, v.fcn, v.mute, v.rdata), v.exp_data);
    start_req(v);
    a0 = acc_total;
    got = 1'b0; lat = -1; rd = 32'hx;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; lat = k; rd = resp_data;
      end
    end
    chk("resp_seen", got, 1);
    chk("latency", lat, v.exp_lat);
    chk("resp_data", rd, v.exp_data);
    @(posedge clk);
    #1;
    chk("bus_issues", acc_total - a0, v.exp_issue);
    $display("txn %0d typ=%0d addr=%h fcn=%0d latency=%0d resp_data=%h issues=%0d",
             idx, v.typ, v.addr, v.fcn, lat, rd, acc_total - a0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            typ   addr          fcn  wdata          rdata          rdy rsp mute exp_data       lat iss
    vecs[0]  = mk(3'd1, 32'h0000_0103, 0, 32'h0,         32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80, 3, 1);
    vecs[1]  = mk(3'd5, 32'h0000_0202, 0, 32'h0,         32'hBEEF_0000, 0, 0, 0, 32'h0000_BEEF, 3, 1);
    vecs[2]  = mk(3'd2, 32'h0000_0202, 0, 32'h0,         32'hBEEF_0000, 0, 0, 0, 32'hFFFF_BEEF, 3, 1);
    vecs[3]  = mk(3'd2, 32'h0000_0012, 1, 32'hAAAA_5678, 32'h0,         3, 0, 0, 32'h0,         6, 1);
    vecs[4]  = mk(3'd3, 32'h0000_0006, 0, 32'h0,         32'h1111_1111, 0, 0, 0, 32'h0,         1, 0);
    vecs[5]  = mk(3'd3, 32'h0000_0008, 0, 32'h0,         32'h0,         0, 0, 1, 32'h0,         6, 1);
    vecs[6]  = mk(3'd4, 32'h0000_0101, 0, 32'h0,         32'h1234_5678, 0, 0, 0, 32'h0000_0056, 3, 1);
    vecs[7]  = mk(3'd1, 32'h0000_0003, 1, 32'h0000_00A5, 32'h0,         0, 2, 0, 32'h0,         5, 1);
    vecs[8]  = mk(3'd2, 32'h0000_0005, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         1, 0);
    vecs[9]  = mk(3'd0, 32'h0000_0010, 0, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 3, 1);
    vecs[10] = mk(3'd3, 32'h0000_0020, 1, 32'h1234_5678, 32'h0,         0, 0, 0, 32'h0,         3, 1);
    vecs[11] = mk(3'd5, 32'h0000_0003, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         1, 0);
    vecs[12] = mk(3'd1, 32'h0000_0100, 0, 32'h0,         32'h0000_00FF, 0, 0, 0, 32'hFFFF_FFFF, 3, 1);
    vecs[13] = mk(3'd2, 32'h0000_0102, 0, 32'h0,         32'h7FFF_1234, 0, 0, 0, 32'h0000_7FFF, 3, 1);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back requests, each driven right after the previous completion
    for (int i = 0; i < 12; i++) run_vec(i);
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    // reset asserted while the adapter waits for a bus response
    start_req(mk(3'd3, 32'h0000_0040, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 0, 0));
    repeat (3) @(negedge clk);
    chk("stall_before_reset", cmiss_stall, 1);
    chk("wait_no_resp", resp_valid, 0);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("async_reset_outputs", all_or(), 32'd0);
    $display("txn reset asserted during WAIT outputs=%h", all_or());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec(12);
    run_vec(13);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_adapter.md
Name: dmem_adapter

Overview:
- Sits between the core's memory stage and the data-memory bus.
- Takes one load/store request per memory-stage instruction and converts it to a word-aligned bus transaction, with byte enables and lane-replicated write data.
- Returns a load result that is right-aligned and sign- or zero-extended.
- Holds the pipeline through `cmiss_stall` until the transaction completes, and reports misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before aborting with `bus_err`. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage request valid; held stable while `cmiss_stall`=1
- req_addr  in  32  byte address
- req_fcn  in  1  1=store, 0=load
- req_typ  in  3  0=X, 1=B, 2=H, 3=W, 4=BU, 5=HU
- req_wdata  in  32  store data, right-aligned
- cmiss_stall  out  1  stall the core pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load data; 0 for stores and errors
- misaligned  out  1  pulse with `resp_valid`: access not naturally aligned
- bus_err  out  1  pulse with `resp_valid`: bus timeout
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  32  `{req_addr[31:2],2'b00}`
- bus_we  out  1  write enable
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_resp_valid  in  1  read data or write acknowledge
- bus_rdata  in  32  read word

Behaviour:
- Reset:
  - rst_n=0 forces state IDLE asynchronously.
  - All outputs are 0 and the timeout counter is 0.
  - A reset mid-transaction abandons the bus transaction; the bus must tolerate this.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With `req_valid`=1, capture addr, fcn, typ and wdata into registers.
  - If misaligned, go to DONE with the misaligned flag set; otherwise go to REQ.
- REQ:
  - Drive `bus_req_valid`=1 with registered addr, we, be and wdata.
  - Go to WAIT in the cycle `bus_req_ready`=1.
- WAIT:
  - `bus_resp_valid` in the same cycle as acceptance is not expected; it is sampled only in WAIT.
  - `bus_resp_valid`=1: capture the extended data and go to DONE.
  - Otherwise, if TIMEOUT_CYCLES>0, the counter increments; on reaching TIMEOUT_CYCLES, go to DONE with `bus_err`=1.
- DONE:
  - `resp_valid`=1 for exactly one cycle, with `misaligned` and `bus_err` as captured.
  - Always return to IDLE. `req_valid` seen during DONE belongs to the completed request and is ignored.
- cmiss_stall:
  - Equals (IDLE & req_valid) | REQ | WAIT. This is combinational from `req_valid` in IDLE.
  - It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency: with an immediate ready and a response one cycle later, request at cycle 0 gives REQ at 1, WAIT at 2, DONE at 3, and the stall covers cycles 0–2. A misaligned request gives DONE at cycle 1.
- Alignment (o = addr[1:0]):
  - H/HU with o[0]=1 is misaligned.
  - W/X with o≠0 is misaligned.
  - Misaligned accesses issue no bus transaction.
  - X is treated as W.
- Byte enables: B/BU `4'b0001<<o`; H/HU `4'b0011<<o`; W `4'b1111`. For loads, `bus_be` is driven identically.
- Write data: B `{4{wdata[7:0]}}`; H `{2{wdata[15:0]}}`; W `wdata`.
- Load extraction: s = `bus_rdata >> (8*o)`.
  - B: sign-extend s[7:0]; BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]; HU: zero-extend s[15:0].
  - W: s.
- Timeout counter clears on entering WAIT.
- Stores complete only on `bus_resp_valid` (write ack); `resp_data`=0.
- Bus outputs are driven from registers only and are 0 outside REQ.

Test Plan:
- Load B, addr 0x103, rdata 0x80FF_1234 → `bus_addr` 0x100, `bus_be` 0x8; `resp_data` 0xFFFF_FF80 at DONE; `cmiss_stall` high cycles 0–2 when ready and response are immediate.
- Load HU, addr 0x202, rdata 0xBEEF_0000 → `bus_be` 0xC; `resp_data` 0x0000_BEEF. Same request as H → 0xFFFF_BEEF.
- Store H, addr 0x12, wdata 0xAAAA_5678 → `bus_we`=1, `bus_be` 0xC, `bus_wdata` 0x5678_5678; holds in REQ 3 cycles while `bus_req_ready`=0; `resp_valid` one cycle after ack.
- Load W, addr 0x6 → no `bus_req_valid`; `misaligned` and `resp_valid` pulse at cycle 1; `resp_data` 0; stall only at cycle 0.
- TIMEOUT_CYCLES=4, bus never responds → DONE 4 cycles after entering WAIT with `bus_err`=1; next request is accepted normally.
- rst_n low during WAIT → all outputs 0 immediately; after release, a new load completes correctly; back-to-back requests are each issued exactly once.
